// File: rtl/rvh_l1d_pkg.sv
// Shared L1D definitions: MESI encoding and the write-back queue issue FSM states.
package rvh_l1d_pkg;

    localparam logic [1:0] MESI_I = 2'd0;
    localparam logic [1:0] MESI_S = 2'd1;
    localparam logic [1:0] MESI_E = 2'd2;
    localparam logic [1:0] MESI_M = 2'd3;

    typedef enum logic [1:0] {
        WBQ_IDLE  = 2'd0,
        WBQ_AW    = 2'd1,
        WBQ_WDATA = 2'd2
    } wbq_state_e;

    function automatic logic mesi_is_dirty(input logic [1:0] mesi);
        return mesi == MESI_M;
    endfunction

endpackage

// File: rtl/rvh_l1d_wbq_beat_mux.sv
// Selects one BUS_BITS-wide beat out of a full cache line.
module rvh_l1d_wbq_beat_mux #(
    parameter  int LINE_BITS = 512,
    parameter  int BUS_BITS  = 64,
    localparam int BEATS     = LINE_BITS / BUS_BITS,
    localparam int SEL_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic [LINE_BITS-1:0] line,
    input  logic [SEL_W-1:0]     sel,
    output logic [BUS_BITS-1:0]  beat
);

    logic [BUS_BITS-1:0] beats [BEATS];

    for (genvar g = 0; g < BEATS; g++) begin : g_split
        assign beats[g] = line[g*BUS_BITS +: BUS_BITS];
    end

    assign beat = beats[sel];

endmodule

// File: rtl/rvh_l1d_wbq.sv
// L1D write-back queue: buffers evicted lines, issues AW (+W burst for dirty lines),
// retires clean lines on AW and dirty lines on B, and answers combinational snoops.
module rvh_l1d_wbq
    import rvh_l1d_pkg::*;
#(
    parameter  int N_ENTRY   = 4,
    parameter  int LINE_BITS = 512,
    parameter  int BUS_BITS  = 64,
    parameter  int ADDR_BITS = 16,
    localparam int IDX_W     = $clog2(N_ENTRY),
    localparam int BEATS     = LINE_BITS / BUS_BITS,
    localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 enq_valid_i,
    output logic                 enq_ready_o,
    input  logic [ADDR_BITS-1:0] enq_addr_i,
    input  logic [1:0]           enq_mesi_i,
    input  logic [LINE_BITS-1:0] enq_data_i,

    input  logic                 snp_valid_i,
    input  logic [ADDR_BITS-1:0] snp_addr_i,
    output logic                 snp_hit_o,
    output logic [IDX_W-1:0]     snp_idx_o,
    output logic [LINE_BITS-1:0] snp_data_o,
    output logic [1:0]           snp_mesi_o,

    input  logic                 chg_en_i,
    input  logic [IDX_W-1:0]     chg_idx_i,
    input  logic [1:0]           chg_mesi_i,

    output logic                 aw_valid_o,
    input  logic                 aw_ready_i,
    output logic [ADDR_BITS-1:0] aw_addr_o,
    output logic [IDX_W-1:0]     aw_id_o,
    output logic                 aw_dirty_o,

    output logic                 w_valid_o,
    input  logic                 w_ready_i,
    output logic [BUS_BITS-1:0]  w_data_o,
    output logic                 w_last_o,

    input  logic                 b_valid_i,
    output logic                 b_ready_o,
    input  logic [IDX_W-1:0]     b_id_i,

    output logic [IDX_W:0]       occupancy_o,
    output logic [1:0]           dbg_state_o
);

    logic [N_ENTRY-1:0]   valid_q;
    logic [N_ENTRY-1:0]   issued_q;
    logic [ADDR_BITS-1:0] addr_q [N_ENTRY];
    logic [1:0]           mesi_q [N_ENTRY];
    logic [LINE_BITS-1:0] data_q [N_ENTRY];

    logic [IDX_W-1:0]     alloc_ptr;
    logic [IDX_W-1:0]     issue_ptr;
    logic [CNT_W-1:0]     cnt_q;
    wbq_state_e           state_q;

    logic enq_fire;
    logic aw_fire;
    logic w_fire;
    logic b_fire;
    logic cur_dirty;

    // Every channel transfers on the cycle where valid and ready are both high;
    // a valid, once raised, holds its payload until that cycle.
    assign enq_ready_o = ~valid_q[alloc_ptr];
    assign enq_fire    = enq_valid_i & enq_ready_o;

    assign cur_dirty   = mesi_is_dirty(mesi_q[issue_ptr]);
    assign aw_valid_o  = (state_q == WBQ_AW);
    assign aw_addr_o   = addr_q[issue_ptr];
    assign aw_id_o     = issue_ptr;
    assign aw_dirty_o  = cur_dirty;
    assign aw_fire     = aw_valid_o & aw_ready_i;

    assign w_valid_o   = (state_q == WBQ_WDATA);
    assign w_last_o    = w_valid_o & (cnt_q == CNT_W'(BEATS - 1));
    assign w_fire      = w_valid_o & w_ready_i;

    // B to a slot that is not awaiting a response is dropped.
    assign b_ready_o   = 1'b1;
    assign b_fire      = b_valid_i & issued_q[b_id_i];

    assign dbg_state_o = state_q;

    rvh_l1d_wbq_beat_mux #(
        .LINE_BITS (LINE_BITS),
        .BUS_BITS  (BUS_BITS)
    ) u_beat_mux (
        .line (data_q[issue_ptr]),
        .sel  (cnt_q),
        .beat (w_data_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            issued_q  <= '0;
            alloc_ptr <= '0;
            issue_ptr <= '0;
            cnt_q     <= '0;
            state_q   <= WBQ_IDLE;
        end else begin
            if (enq_fire) begin
                valid_q[alloc_ptr] <= 1'b1;
                alloc_ptr          <= alloc_ptr + IDX_W'(1);
            end

            case (state_q)
                WBQ_IDLE: begin
                    if (valid_q[issue_ptr] && !issued_q[issue_ptr]) begin
                        state_q <= WBQ_AW;
                    end
                end
                WBQ_AW: begin
                    if (aw_fire) begin
                        if (cur_dirty) begin
                            issued_q[issue_ptr] <= 1'b1;
                            cnt_q               <= '0;
                            state_q             <= WBQ_WDATA;
                        end else begin
                            // Clean lines need no data phase and no response.
                            valid_q[issue_ptr] <= 1'b0;
                            issue_ptr          <= issue_ptr + IDX_W'(1);
                            state_q            <= WBQ_IDLE;
                        end
                    end
                end
                WBQ_WDATA: begin
                    if (w_fire) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (w_last_o) begin
                            issue_ptr <= issue_ptr + IDX_W'(1);
                            state_q   <= WBQ_IDLE;
                        end
                    end
                end
                default: state_q <= WBQ_IDLE;
            endcase

            if (b_fire) begin
                valid_q[b_id_i]  <= 1'b0;
                issued_q[b_id_i] <= 1'b0;
            end
        end
    end

    // Payload storage carries no reset; liveness is tracked solely by valid_q.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            addr_q[alloc_ptr] <= enq_addr_i;
            mesi_q[alloc_ptr] <= enq_mesi_i;
            data_q[alloc_ptr] <= enq_data_i;
        end
        if (chg_en_i && valid_q[chg_idx_i]) begin
            mesi_q[chg_idx_i] <= chg_mesi_i;
        end
    end

    always_comb begin
        snp_hit_o  = 1'b0;
        snp_idx_o  = '0;
        snp_data_o = '0;
        snp_mesi_o = '0;
        // Scan downward so the lowest matching index is the one left standing.
        for (int i = N_ENTRY - 1; i >= 0; i--) begin
            if (snp_valid_i && valid_q[i] && (addr_q[i] == snp_addr_i)) begin
                snp_hit_o  = 1'b1;
                snp_idx_o  = IDX_W'(i);
                snp_data_o = data_q[i];
                snp_mesi_o = mesi_q[i];
            end
        end
    end

    always_comb begin
        occupancy_o = '0;
        for (int i = 0; i < N_ENTRY; i++) begin
            occupancy_o = occupancy_o + (IDX_W + 1)'(valid_q[i]);
        end
    end

endmodule

// File: tb/tb_rvh_l1d_wbq.sv
// Self-checking bench for rvh_l1d_wbq: directed scenarios plus a randomized run
// checked against a slot/queue-level reference model.
module tb_rvh_l1d_wbq;

    localparam int N_ENTRY   = 4;
    localparam int LINE_BITS = 512;
    localparam int BUS_BITS  = 64;
    localparam int ADDR_BITS = 16;
    localparam int IDX_W     = 2;
    localparam int BEATS     = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enq_valid;
    logic                 enq_ready_o;
    logic [ADDR_BITS-1:0] enq_addr;
    logic [1:0]           enq_mesi;
    logic [LINE_BITS-1:0] enq_data;
    logic                 snp_valid;
    logic [ADDR_BITS-1:0] snp_addr;
    logic                 snp_hit_o;
    logic [IDX_W-1:0]     snp_idx_o;
    logic [LINE_BITS-1:0] snp_data_o;
    logic [1:0]           snp_mesi_o;
    logic                 chg_en;
    logic [IDX_W-1:0]     chg_idx;
    logic [1:0]           chg_mesi;
    logic                 aw_valid_o;
    logic                 aw_ready;
    logic [ADDR_BITS-1:0] aw_addr_o;
    logic [IDX_W-1:0]     aw_id_o;
    logic                 aw_dirty_o;
    logic                 w_valid_o;
    logic                 w_ready;
    logic [BUS_BITS-1:0]  w_data_o;
    logic                 w_last_o;
    logic                 b_valid;
    logic                 b_ready_o;
    logic [IDX_W-1:0]     b_id;
    logic [IDX_W:0]       occupancy_o;
    logic [1:0]           dbg_state_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: slot-level liveness plus an issue-order queue.
    logic                 m_valid  [N_ENTRY];
    logic                 m_wait_b [N_ENTRY];
    logic [ADDR_BITS-1:0] m_addr   [N_ENTRY];
    logic [1:0]           m_mesi   [N_ENTRY];
    logic [LINE_BITS-1:0] m_data   [N_ENTRY];
    logic [IDX_W-1:0]     exp_q[$];
    int                   m_alloc;
    int                   m_count;
    bit                   m_burst;
    int                   m_burst_slot;
    int                   m_burst_beat;

    rvh_l1d_wbq #(
        .N_ENTRY   (N_ENTRY),
        .LINE_BITS (LINE_BITS),
        .BUS_BITS  (BUS_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enq_valid_i (enq_valid),
        .enq_ready_o (enq_ready_o),
        .enq_addr_i  (enq_addr),
        .enq_mesi_i  (enq_mesi),
        .enq_data_i  (enq_data),
        .snp_valid_i (snp_valid),
        .snp_addr_i  (snp_addr),
        .snp_hit_o   (snp_hit_o),
        .snp_idx_o   (snp_idx_o),
        .snp_data_o  (snp_data_o),
        .snp_mesi_o  (snp_mesi_o),
        .chg_en_i    (chg_en),
        .chg_idx_i   (chg_idx),
        .chg_mesi_i  (chg_mesi),
        .aw_valid_o  (aw_valid_o),
        .aw_ready_i  (aw_ready),
        .aw_addr_o   (aw_addr_o),
        .aw_id_o     (aw_id_o),
        .aw_dirty_o  (aw_dirty_o),
        .w_valid_o   (w_valid_o),
        .w_ready_i   (w_ready),
        .w_data_o    (w_data_o),
        .w_last_o    (w_last_o),
        .b_valid_i   (b_valid),
        .b_ready_o   (b_ready_o),
        .b_id_i      (b_id),
        .occupancy_o (occupancy_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enq_valid = 1'b0; enq_addr = '0; enq_mesi = '0; enq_data = '0;
        snp_valid = 1'b0; snp_addr = '0;
        chg_en = 1'b0; chg_idx = '0; chg_mesi = '0;
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_id = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- helpers / drivers ----------------
    function automatic logic [LINE_BITS-1:0] beat_index_line();
        logic [LINE_BITS-1:0] l;
        for (int k = 0; k < BEATS; k++) l[k*BUS_BITS +: BUS_BITS] = 64'(k);
        return l;
    endfunction

    function automatic logic [LINE_BITS-1:0] rand_line();
        logic [LINE_BITS-1:0] l;
        for (int i = 0; i < LINE_BITS / 32; i++) l[i*32 +: 32] = $urandom();
        return l;
    endfunction

    task automatic enqueue(input logic [ADDR_BITS-1:0] a, input logic [1:0] m,
                           input logic [LINE_BITS-1:0] d);
        enq_valid = 1'b1; enq_addr = a; enq_mesi = m; enq_data = d;
        #1;
        checks++;
        if (enq_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL enq_ready_on_enqueue: got %b expected 1", enq_ready_o);
        end
        step();
        enq_valid = 1'b0;
    endtask

    task automatic do_aw(output logic [ADDR_BITS-1:0] a, output logic [IDX_W-1:0] id,
                         output logic dirty);
        bit ok = 0;
        a = '0; id = '0; dirty = 1'b0;
        aw_ready = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (aw_valid_o) begin
                a = aw_addr_o; id = aw_id_o; dirty = aw_dirty_o; ok = 1;
            end
            step();
        end
        aw_ready = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL aw_timeout: got no aw_valid expected handshake within 20 cycles");
        end
    endtask

    task automatic do_w(input logic [LINE_BITS-1:0] line, input int stall_at, input int stall_n);
        int beat = 0;
        logic [BUS_BITS-1:0] exp_beat;
        w_ready = 1'b1;
        for (int t = 0; t < 100 && beat < BEATS; t++) begin
            if (w_valid_o) begin
                exp_beat = line[beat*BUS_BITS +: BUS_BITS];
                if (beat == stall_at) begin
                    w_ready = 1'b0;
                    for (int s = 0; s < stall_n; s++) begin
                        step();
                        checks++;
                        if (w_valid_o !== 1'b1 || w_data_o !== exp_beat) begin
                            failures++;
                            $display("FAIL w_stall_hold: got valid=%b data=%h expected valid=1 data=%h",
                                     w_valid_o, w_data_o, exp_beat);
                        end
                    end
                    w_ready = 1'b1;
                end
                checks++;
                if (w_data_o !== exp_beat) begin
                    failures++;
                    $display("FAIL w_data beat %0d: got %h expected %h", beat, w_data_o, exp_beat);
                end
                checks++;
                if (w_last_o !== (beat == BEATS - 1)) begin
                    failures++;
                    $display("FAIL w_last beat %0d: got %b expected %b", beat, w_last_o, beat == BEATS - 1);
                end
                beat++;
            end
            step();
        end
        w_ready = 1'b0;
        checks++;
        if (beat != BEATS) begin
            failures++;
            $display("FAIL w_beat_count: got %0d expected %0d", beat, BEATS);
        end
        checks++;
        if (w_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL w_valid_after_last: got %b expected 0", w_valid_o);
        end
    endtask

    task automatic send_b(input logic [IDX_W-1:0] id);
        b_valid = 1'b1; b_id = id;
        step();
        b_valid = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        apply_reset();
        snp_valid = 1'b1; snp_addr = '0;
        #1;
        checks++;
        if (enq_ready_o !== 1'b1 || aw_valid_o !== 1'b0 || w_valid_o !== 1'b0 || w_last_o !== 1'b0 ||
            snp_hit_o !== 1'b0 || occupancy_o !== 3'd0 || b_ready_o !== 1'b1 || dbg_state_o !== 2'd0) begin
            failures++;
            $display("FAIL reset_outputs: got enq_rdy=%b aw_v=%b w_v=%b w_last=%b hit=%b occ=%0d b_rdy=%b st=%0d expected 1 0 0 0 0 0 1 0",
                     enq_ready_o, aw_valid_o, w_valid_o, w_last_o, snp_hit_o, occupancy_o, b_ready_o, dbg_state_o);
        end
        snp_valid = 1'b0;
    endtask

    task automatic test_dirty_line();
        logic [LINE_BITS-1:0] line = beat_index_line();
        logic [ADDR_BITS-1:0] a; logic [IDX_W-1:0] id; logic dirty;
        apply_reset();
        enqueue(16'h0123, 2'd3, line);
        checks++;
        if (occupancy_o !== 3'd1) begin
            failures++; $display("FAIL dirty_occ_enq: got %0d expected 1", occupancy_o);
        end
        do_aw(a, id, dirty);
        checks++;
        if (a !== 16'h0123 || id !== 2'd0 || dirty !== 1'b1) begin
            failures++; $display("FAIL dirty_aw: got addr=%h id=%0d dirty=%b expected 0123 0 1", a, id, dirty);
        end
        do_w(line, 3, 2);
        checks++;
        if (occupancy_o !== 3'd1) begin
            failures++; $display("FAIL dirty_occ_await_b: got %0d expected 1", occupancy_o);
        end
        send_b(2'd0);
        checks++;
        if (occupancy_o !== 3'd0 || enq_ready_o !== 1'b1) begin
            failures++; $display("FAIL dirty_after_b: got occ=%0d rdy=%b expected 0 1", occupancy_o, enq_ready_o);
        end
    endtask

    task automatic test_clean_line();
        logic [ADDR_BITS-1:0] a; logic [IDX_W-1:0] id; logic dirty;
        logic [ADDR_BITS-1:0] addr = ADDR_BITS'($urandom());
        apply_reset();
        enqueue(addr, 2'd1, rand_line());
        checks++;
        if (occupancy_o !== 3'd1) begin
            failures++; $display("FAIL clean_occ_enq: got %0d expected 1", occupancy_o);
        end
        do_aw(a, id, dirty);
        checks++;
        if (a !== addr || id !== 2'd0 || dirty !== 1'b0) begin
            failures++; $display("FAIL clean_aw: got addr=%h id=%0d dirty=%b expected %h 0 0", a, id, dirty, addr);
        end
        checks++;
        if (occupancy_o !== 3'd0) begin
            failures++; $display("FAIL clean_occ_retire: got %0d expected 0", occupancy_o);
        end
        w_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w_valid_o !== 1'b0) begin
                failures++; $display("FAIL clean_no_w: got w_valid=%b expected 0", w_valid_o);
            end
            step();
        end
        w_ready = 1'b0;
    endtask

    task automatic test_full();
        logic [ADDR_BITS-1:0] addrs [N_ENTRY];
        logic [LINE_BITS-1:0] lines [N_ENTRY];
        logic [ADDR_BITS-1:0] a; logic [IDX_W-1:0] id; logic dirty;
        logic [LINE_BITS-1:0] extra = rand_line();
        apply_reset();
        for (int i = 0; i < N_ENTRY; i++) begin
            addrs[i] = ADDR_BITS'($urandom());
            lines[i] = rand_line();
            enqueue(addrs[i], 2'd3, lines[i]);
            exp_q.push_back(IDX_W'(i));
        end
        checks++;
        if (enq_ready_o !== 1'b0 || occupancy_o !== 3'd4) begin
            failures++; $display("FAIL full_state: got rdy=%b occ=%0d expected 0 4", enq_ready_o, occupancy_o);
        end
        for (int i = 0; i < N_ENTRY; i++) begin
            logic [IDX_W-1:0] head = exp_q.pop_front();
            do_aw(a, id, dirty);
            checks++;
            if (id !== head || a !== addrs[head] || dirty !== 1'b1) begin
                failures++; $display("FAIL full_aw_order: got id=%0d addr=%h dirty=%b expected %0d %h 1",
                                     id, a, dirty, head, addrs[head]);
            end
            do_w(lines[head], -1, 0);
        end
        send_b(2'd2);
        checks++;
        if (occupancy_o !== 3'd3 || enq_ready_o !== 1'b0) begin
            failures++; $display("FAIL full_b2: got occ=%0d rdy=%b expected 3 0", occupancy_o, enq_ready_o);
        end
        send_b(2'd0);
        checks++;
        if (occupancy_o !== 3'd2 || enq_ready_o !== 1'b1) begin
            failures++; $display("FAIL full_b0: got occ=%0d rdy=%b expected 2 1", occupancy_o, enq_ready_o);
        end
        enqueue(16'hBEEF, 2'd3, extra);
        do_aw(a, id, dirty);
        checks++;
        if (id !== 2'd0 || a !== 16'hBEEF) begin
            failures++; $display("FAIL full_reuse_slot0: got id=%0d addr=%h expected 0 beef", id, a);
        end
        do_w(extra, -1, 0);
        send_b(2'd1);
        send_b(2'd3);
        send_b(2'd0);
        checks++;
        if (occupancy_o !== 3'd0) begin
            failures++; $display("FAIL full_drain: got %0d expected 0", occupancy_o);
        end
    endtask

    task automatic test_snoop_chg();
        logic [LINE_BITS-1:0] line = beat_index_line();
        logic [LINE_BITS-1:0] line2 = rand_line();
        logic [ADDR_BITS-1:0] a; logic [IDX_W-1:0] id; logic dirty;
        apply_reset();
        enqueue(16'h0123, 2'd3, line);
        snp_valid = 1'b1; snp_addr = 16'h0123;
        #1;
        checks++;
        if (snp_hit_o !== 1'b1 || snp_idx_o !== 2'd0 || snp_data_o !== line || snp_mesi_o !== 2'd3) begin
            failures++; $display("FAIL snoop_hit: got hit=%b idx=%0d mesi=%0d expected 1 0 3", snp_hit_o, snp_idx_o, snp_mesi_o);
        end
        snp_addr = 16'h0456;
        #1;
        checks++;
        if (snp_hit_o !== 1'b0 || snp_data_o !== '0 || snp_mesi_o !== 2'd0) begin
            failures++; $display("FAIL snoop_miss: got hit=%b mesi=%0d expected 0 0", snp_hit_o, snp_mesi_o);
        end
        snp_valid = 1'b0; snp_addr = 16'h0123;
        #1;
        checks++;
        if (snp_hit_o !== 1'b0) begin
            failures++; $display("FAIL snoop_not_valid: got hit=%b expected 0", snp_hit_o);
        end
        chg_en = 1'b1; chg_idx = 2'd0; chg_mesi = 2'd0;
        step();
        chg_en = 1'b0;
        checks++;
        if (aw_valid_o !== 1'b1 || aw_dirty_o !== 1'b0) begin
            failures++; $display("FAIL chg_before_aw: got aw_valid=%b dirty=%b expected 1 0", aw_valid_o, aw_dirty_o);
        end
        do_aw(a, id, dirty);
        checks++;
        if (dirty !== 1'b0 || occupancy_o !== 3'd0 || w_valid_o !== 1'b0) begin
            failures++; $display("FAIL chg_clean_retire: got dirty=%b occ=%0d w_valid=%b expected 0 0 0", dirty, occupancy_o, w_valid_o);
        end
        // Downgrade after the dirty AW must not cancel the data burst.
        enqueue(16'h0300, 2'd3, line2);
        do_aw(a, id, dirty);
        checks++;
        if (id !== 2'd1 || dirty !== 1'b1) begin
            failures++; $display("FAIL chg_second_aw: got id=%0d dirty=%b expected 1 1", id, dirty);
        end
        chg_en = 1'b1; chg_idx = 2'd1; chg_mesi = 2'd0;
        step();
        chg_en = 1'b0;
        do_w(line2, -1, 0);
        // B and MESI update to the same slot in one cycle: the slot retires.
        b_valid = 1'b1; b_id = 2'd1;
        chg_en = 1'b1; chg_idx = 2'd1; chg_mesi = 2'd3;
        step();
        b_valid = 1'b0; chg_en = 1'b0;
        snp_valid = 1'b1; snp_addr = 16'h0300;
        #1;
        checks++;
        if (occupancy_o !== 3'd0 || snp_hit_o !== 1'b0) begin
            failures++; $display("FAIL b_beats_chg: got occ=%0d hit=%b expected 0 0", occupancy_o, snp_hit_o);
        end
        snp_valid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        logic [LINE_BITS-1:0] line = beat_index_line();
        logic [ADDR_BITS-1:0] a; logic [IDX_W-1:0] id; logic dirty;
        apply_reset();
        enqueue(16'h0777, 2'd3, line);
        do_aw(a, id, dirty);
        w_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (w_valid_o !== 1'b1 || w_data_o !== 64'd4) begin
            failures++; $display("FAIL mid_burst_beat4: got valid=%b data=%h expected 1 4", w_valid_o, w_data_o);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (w_valid_o !== 1'b0 || occupancy_o !== 3'd0 || enq_ready_o !== 1'b1 || aw_valid_o !== 1'b0) begin
            failures++; $display("FAIL mid_burst_reset: got w_v=%b occ=%0d rdy=%b aw_v=%b expected 0 0 1 0",
                                 w_valid_o, occupancy_o, enq_ready_o, aw_valid_o);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (w_valid_o !== 1'b0) begin
                failures++; $display("FAIL mid_burst_no_more_w: got %b expected 0", w_valid_o);
            end
        end
        w_ready = 1'b0;
    endtask

    task automatic test_enq_retire_same();
        logic [LINE_BITS-1:0] line = rand_line();
        logic [ADDR_BITS-1:0] a; logic [IDX_W-1:0] id; logic dirty;
        apply_reset();
        enqueue(16'h0010, 2'd3, line);
        do_aw(a, id, dirty);
        do_w(line, -1, 0);
        enq_valid = 1'b1; enq_addr = 16'h0020; enq_mesi = 2'd1; enq_data = rand_line();
        b_valid = 1'b1; b_id = 2'd0;
        step();
        enq_valid = 1'b0; b_valid = 1'b0;
        checks++;
        if (occupancy_o !== 3'd1) begin
            failures++; $display("FAIL enq_retire_occ: got %0d expected 1", occupancy_o);
        end
        snp_valid = 1'b1; snp_addr = 16'h0020;
        #1;
        checks++;
        if (snp_hit_o !== 1'b1 || snp_idx_o !== 2'd1) begin
            failures++; $display("FAIL enq_retire_new: got hit=%b idx=%0d expected 1 1", snp_hit_o, snp_idx_o);
        end
        snp_addr = 16'h0010;
        #1;
        checks++;
        if (snp_hit_o !== 1'b0) begin
            failures++; $display("FAIL enq_retire_old: got hit=%b expected 0", snp_hit_o);
        end
        snp_valid = 1'b0;
    endtask

    // ---------------- randomized run against the model ----------------
    task automatic rand_cycle(input bit drain);
        bit enq_fire, aw_fire, w_fire, b_fire;
        int bid;
        logic exp_hit; logic [IDX_W-1:0] exp_idx; logic [LINE_BITS-1:0] exp_data; logic [1:0] exp_mesi;
        logic [IDX_W-1:0] head;
        logic [LINE_BITS-1:0] cur_line;
        logic [BUS_BITS-1:0] exp_beat;

        enq_valid = drain ? 1'b0 : ($urandom_range(0, 2) != 0);
        enq_addr  = ADDR_BITS'($urandom_range(0, 7));
        enq_mesi  = 2'($urandom_range(0, 3));
        enq_data  = rand_line();
        aw_ready  = drain ? 1'b1 : 1'($urandom_range(0, 1));
        w_ready   = drain ? 1'b1 : 1'($urandom_range(0, 1));
        snp_valid = 1'b1;
        snp_addr  = ADDR_BITS'($urandom_range(0, 7));
        bid = $urandom_range(0, N_ENTRY - 1);
        if (drain) begin
            for (int i = N_ENTRY - 1; i >= 0; i--) if (m_wait_b[i]) bid = i;
        end
        b_id    = IDX_W'(bid);
        b_valid = (drain || $urandom_range(0, 2) == 0) && !(m_burst && bid == m_burst_slot);
        #1;

        checks++;
        if (occupancy_o !== (IDX_W + 1)'(m_count)) begin
            failures++; $display("FAIL rand_occupancy: got %0d expected %0d", occupancy_o, m_count);
        end
        checks++;
        if (enq_ready_o !== !m_valid[m_alloc]) begin
            failures++; $display("FAIL rand_enq_ready: got %b expected %b", enq_ready_o, !m_valid[m_alloc]);
        end
        exp_hit = 1'b0; exp_idx = '0; exp_data = '0; exp_mesi = '0;
        for (int i = 0; i < N_ENTRY; i++) begin
            if (!exp_hit && m_valid[i] && m_addr[i] == snp_addr) begin
                exp_hit = 1'b1; exp_idx = IDX_W'(i); exp_data = m_data[i]; exp_mesi = m_mesi[i];
            end
        end
        checks++;
        if (snp_hit_o !== exp_hit || snp_idx_o !== exp_idx || snp_data_o !== exp_data || snp_mesi_o !== exp_mesi) begin
            failures++; $display("FAIL rand_snoop addr %0h: got hit=%b idx=%0d mesi=%0d expected %b %0d %0d",
                                 snp_addr, snp_hit_o, snp_idx_o, snp_mesi_o, exp_hit, exp_idx, exp_mesi);
        end
        if (w_valid_o) begin
            checks++;
            if (!m_burst) begin
                failures++; $display("FAIL rand_unexpected_w: got w_valid=1 expected 0");
            end else begin
                cur_line = m_data[m_burst_slot];
                exp_beat = cur_line[m_burst_beat*BUS_BITS +: BUS_BITS];
                if (w_data_o !== exp_beat || w_last_o !== (m_burst_beat == BEATS - 1)) begin
                    failures++; $display("FAIL rand_w_beat %0d: got data=%h last=%b expected %h %b",
                                         m_burst_beat, w_data_o, w_last_o, exp_beat, m_burst_beat == BEATS - 1);
                end
            end
        end
        if (aw_valid_o) begin
            checks++;
            if (m_burst || exp_q.size() == 0) begin
                failures++; $display("FAIL rand_unexpected_aw: got aw_valid=1 expected 0");
            end else begin
                head = exp_q[0];
                if (aw_id_o !== head || aw_addr_o !== m_addr[head] || aw_dirty_o !== (m_mesi[head] == 2'd3)) begin
                    failures++; $display("FAIL rand_aw: got id=%0d addr=%h dirty=%b expected %0d %h %b",
                                         aw_id_o, aw_addr_o, aw_dirty_o, head, m_addr[head], m_mesi[head] == 2'd3);
                end
            end
        end

        enq_fire = enq_valid && !m_valid[m_alloc];
        aw_fire  = aw_valid_o && aw_ready && !m_burst && exp_q.size() != 0;
        w_fire   = w_valid_o && w_ready && m_burst;
        b_fire   = b_valid && m_wait_b[bid];
        if (aw_fire) begin
            head = exp_q.pop_front();
            if (m_mesi[head] == 2'd3) begin
                m_burst = 1; m_burst_slot = head; m_burst_beat = 0;
            end else begin
                m_valid[head] = 1'b0; m_count--;
            end
        end else if (w_fire) begin
            m_burst_beat++;
            if (m_burst_beat == BEATS) begin
                m_burst = 0; m_wait_b[m_burst_slot] = 1'b1;
            end
        end
        if (b_fire) begin
            m_wait_b[bid] = 1'b0; m_valid[bid] = 1'b0; m_count--;
        end
        if (enq_fire) begin
            m_valid[m_alloc] = 1'b1; m_addr[m_alloc] = enq_addr; m_mesi[m_alloc] = enq_mesi;
            m_data[m_alloc] = enq_data; exp_q.push_back(IDX_W'(m_alloc));
            m_alloc = (m_alloc + 1) % N_ENTRY; m_count++;
        end
        step();
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < N_ENTRY; i++) begin
            m_valid[i] = 1'b0; m_wait_b[i] = 1'b0; m_addr[i] = '0; m_mesi[i] = '0; m_data[i] = '0;
        end
        exp_q.delete();
        m_alloc = 0; m_count = 0; m_burst = 0; m_burst_slot = 0; m_burst_beat = 0;
        for (int cyc = 0; cyc < 1500; cyc++) rand_cycle(1'b0);
        for (int cyc = 0; cyc < 400 && m_count != 0; cyc++) rand_cycle(1'b1);
        idle_inputs();
        #1;
        checks++;
        if (m_count != 0 || occupancy_o !== 3'd0) begin
            failures++; $display("FAIL rand_drain: got model=%0d occ=%0d expected 0 0", m_count, occupancy_o);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_dirty_line();
        test_clean_line();
        test_full();
        test_snoop_chg();
        test_reset_mid_burst();
        test_enq_retire_same();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
